// File: rtl/id_ex_stage_pkg.sv
// Shared CPU package for the ID/EX pipeline slice.
// Holds the opcode constants, the two-entry buffer state encoding and the
// opcode classification helpers used by id_ex_stage.
// Optional feature macro: ID_EX_LUI_EN (LUI treated as an immediate opcode).
package id_ex_stage_pkg;

  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // Logical immediates are zero-extended rather than sign-extended.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  // Opcodes whose ALU operand B is the immediate instead of rt.
  function automatic logic is_imm_op(input logic [5:0] op);
    logic hit;
    hit = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
          (op == OP_ANDI) || (op == OP_ORI)   || (op == OP_XORI) ||
          (op == OP_LW)   || (op == OP_SW);
`ifdef ID_EX_LUI_EN
    hit = hit || (op == OP_LUI);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/id_ex_stage_pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready buffer (main register + skid).
// in_ready is registered, so there is no combinational path from out_ready
// back to in_ready; the skid entry absorbs the word accepted while the
// downstream stalls.
// Ports: clk, reset (async active-high), flush (sync squash),
//        in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module pipe_skid_buffer
  import id_ex_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state;
  logic [W-1:0] skid;
  logic         accept;
  logic         drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Buffer FSM; out_data is the main register, out_valid/in_ready track state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else if (flush) begin
      // Squash everything, including a word offered this same cycle.
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_data <= in_data;
          end else if (accept) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            out_data <= skid;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with skid buffering.
// Selects the final immediate (zero-extension for logical ops, optional LUI
// shift) and ALU operand B, buffers the word through pipe_skid_buffer and
// counts downstream bubble cycles (saturating, survives flush).
// Optional feature macro: ID_EX_LUI_EN.
// Ports: clk, reset, flush, in_valid/in_ready, in_opcode/in_rs_data/
//        in_rt_data/in_rd/in_imm_ext, out_valid/out_ready, out_opcode/out_rd/
//        out_a/out_b/out_imm, bubble_count.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_imm_ext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam int PAY_W = 11 + 3 * DATA_W;

  logic [DATA_W-1:0] imm_sel;
  logic [DATA_W-1:0] b_sel;
  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;

  // Final immediate and operand B selection from the incoming opcode.
  always_comb begin
    imm_sel = in_imm_ext;
    if (is_zext_op(in_opcode)) begin
      imm_sel = {{(DATA_W-16){1'b0}}, in_imm_ext[15:0]};
`ifdef ID_EX_LUI_EN
    end else if (in_opcode == OP_LUI) begin
      imm_sel = DATA_W'({in_imm_ext[15:0], 16'h0000});
`endif
    end else begin
      imm_sel = in_imm_ext;
    end
    if (is_imm_op(in_opcode)) begin
      b_sel = imm_sel;
    end else begin
      b_sel = in_rt_data;
    end
  end

  assign pay_in = {in_opcode, in_rd, in_rs_data, b_sel, imm_sel};

  pipe_skid_buffer #(.W(PAY_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  // Outputs are slices of the buffer's main register, hence registered.
  assign out_opcode = pay_out[PAY_W-1 -: 6];
  assign out_rd     = pay_out[PAY_W-7 -: 5];
  assign out_a      = pay_out[3*DATA_W-1 -: DATA_W];
  assign out_b      = pay_out[2*DATA_W-1 -: DATA_W];
  assign out_imm    = pay_out[DATA_W-1:0];

  // Saturating bubble counter; deliberately not cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (out_ready && !out_valid && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end else begin
      bubble_count <= bubble_count;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a queue-based reference model plus a
// few directed scenarios with literal expectations, then random traffic.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_opcode = 6'h00;
  logic [31:0] in_rs_data = 32'h0;
  logic [31:0] in_rt_data = 32'h0;
  logic [4:0]  in_rd = 5'h0;
  logic [31:0] in_imm_ext = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [31:0] out_a, out_b, out_imm;
  logic [15:0] bubble_count;

  logic        in_ready4, out_valid4;
  logic [5:0]  out_opcode4;
  logic [4:0]  out_rd4;
  logic [31:0] out_a4, out_b4, out_imm4;
  logic [3:0]  bubble_count4;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_rd(in_rd), .in_imm_ext(in_imm_ext), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm), .bubble_count(bubble_count)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_opcode(in_opcode), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_rd(in_rd), .in_imm_ext(in_imm_ext), .out_valid(out_valid4), .out_ready(out_ready),
    .out_opcode(out_opcode4), .out_rd(out_rd4), .out_a(out_a4), .out_b(out_b4),
    .out_imm(out_imm4), .bubble_count(bubble_count4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } word_t;

  word_t q[$];
  int    bub = 0;
  int    bub4 = 0;

  function automatic logic [31:0] exp_imm(input logic [5:0] op, input logic [31:0] imm);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0000, imm[15:0]};
`ifdef ID_EX_LUI_EN
    if (op == 6'h0F) return {imm[15:0], 16'h0000};
`endif
    return imm;
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    logic [5:0] list [8] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    foreach (list[i]) if (list[i] == op) return 1'b1;
`ifdef ID_EX_LUI_EN
    if (op == 6'h0F) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Model: a FIFO of at most two words; head is what the stage presents.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      bub = 0;
      bub4 = 0;
    end else begin
      logic acc, drn;
      word_t w;
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (out_ready && q.size() == 0) begin
        if (bub < 65535) bub++;
        if (bub4 < 15) bub4++;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          w.op  = in_opcode;
          w.rd  = in_rd;
          w.a   = in_rs_data;
          w.imm = exp_imm(in_opcode, in_imm_ext);
          w.b   = uses_imm(in_opcode) ? w.imm : in_rt_data;
          q.push_back(w);
        end
      end
    end
  end

  // Compare process: DUT vs model every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("bubble_count", 64'(bubble_count), 64'(bub));
      chk("bubble_count4", 64'(bubble_count4), 64'(bub4));
      if (q.size() != 0) begin
        chk("out_opcode", 64'(out_opcode), 64'(q[0].op));
        chk("out_rd", 64'(out_rd), 64'(q[0].rd));
        chk("out_a", 64'(out_a), 64'(q[0].a));
        chk("out_b", 64'(out_b), 64'(q[0].b));
        chk("out_imm", 64'(out_imm), 64'(q[0].imm));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [5:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [31:0] imm, input logic ordy);
    in_valid   = v;
    in_opcode  = op;
    in_rs_data = rs;
    in_rt_data = rt;
    in_rd      = rs[4:0];
    in_imm_ext = imm;
    out_ready  = ordy;
  endtask

  initial begin
    logic [5:0] ops [12] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                             6'h0F, 6'h23, 6'h2B, 6'h00, 6'h04, 6'h3F};
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bubble", 64'(bubble_count), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_op_rd", 64'({out_opcode, out_rd}), 64'd0);
    reset = 1'b0;

    // Immediate selection with literal expectations.
    put(1'b1, 6'h08, 32'hAAAA0001, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    step();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_b", 64'(out_b), 64'hFFFFFFFF);
    chk("addi_a", 64'(out_a), 64'hAAAA0001);
    put(1'b1, 6'h0D, 32'hAAAA0002, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    step();
    chk("ori_imm", 64'(out_imm), 64'h0000FFFF);
    chk("ori_b", 64'(out_b), 64'h0000FFFF);
    put(1'b1, 6'h0F, 32'hAAAA0003, 32'h12345678, 32'h00008000, 1'b1);
    step();
`ifdef ID_EX_LUI_EN
    chk("lui_imm", 64'(out_imm), 64'h80000000);
    chk("lui_b", 64'(out_b), 64'h80000000);
`else
    chk("lui_imm", 64'(out_imm), 64'h00008000);
    chk("lui_b", 64'(out_b), 64'h12345678);
`endif
    put(1'b1, 6'h00, 32'hAAAA0004, 32'h12345678, 32'hFFFF8000, 1'b1);
    step();
    chk("rtype_b", 64'(out_b), 64'h12345678);
    chk("rtype_imm", 64'(out_imm), 64'hFFFF8000);
    put(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(out_valid), 64'd0);

    // Fill both entries under stall, then drain in order.
    put(1'b1, 6'h00, 32'h11, 32'h1, 32'h1, 1'b0);
    step();
    put(1'b1, 6'h00, 32'h22, 32'h2, 32'h2, 1'b0);
    step();
    chk("two_in_ready", 64'(in_ready), 64'd0);
    chk("two_head", 64'(out_a), 64'h11);
    put(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1);
    step();
    chk("drain1_a", 64'(out_a), 64'h22);
    chk("drain1_ready", 64'(in_ready), 64'd1);
    chk("drain1_valid", 64'(out_valid), 64'd1);
    step();
    chk("drain2_valid", 64'(out_valid), 64'd0);

    // Flush from TWO while a new word is offered.
    put(1'b1, 6'h00, 32'h33, 32'h3, 32'h3, 1'b0);
    step();
    put(1'b1, 6'h00, 32'h44, 32'h4, 32'h4, 1'b0);
    step();
    chk("f2_in_ready", 64'(in_ready), 64'd0);
    put(1'b1, 6'h00, 32'h55, 32'h5, 32'h5, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f2_valid", 64'(out_valid), 64'd0);
    chk("f2_ready", 64'(in_ready), 64'd1);
    put(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1);
    step();
    chk("f2_nostale1", 64'(out_valid), 64'd0);
    step();
    chk("f2_nostale2", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while holding one word.
    put(1'b1, 6'h00, 32'h66, 32'h6, 32'h6, 1'b0);
    step();
    put(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_bubble", 64'(bubble_count), 64'd0);
    chk("arst_bubble4", 64'(bubble_count4), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_a", 64'(out_a), 64'd0);
    step();
    reset = 1'b0;

    // Bubble counter saturation for the 4-bit instance.
    put(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1);
    repeat (20) step();
    chk("sat4_20", 64'(bubble_count4), 64'd15);
    chk("bub16_20", 64'(bubble_count), 64'd20);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    repeat (5) step();
    chk("sat4_hold", 64'(bubble_count4), 64'd15);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_opcode  = ops[$urandom_range(0, 11)];
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      in_rd      = 5'($urandom);
      in_imm_ext = ($urandom_range(0, 1) != 0) ? {{16{1'b1}}, 16'($urandom)} : {16'h0000, 16'($urandom)};
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operand and immediate buses.
REQ-002 Parameter CNT_W, default 16, width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces reset state immediately, released synchronously to clk.
REQ-005 in_valid  input  1  upstream (decode/sign-extend) word valid.
REQ-006 in_ready  output  1  stage can accept a word this cycle.
REQ-007 flush  input  1  synchronous squash of all held words (branch/exception).
REQ-008 in_opcode  input  6  instruction opcode.
REQ-009 in_rs_data  input  DATA_W  register-file read port A.
REQ-010 in_rt_data  input  DATA_W  register-file read port B.
REQ-011 in_rd  input  5  destination register index.
REQ-012 in_imm_ext  input  DATA_W  immediate already sign-extended from 16 bits by the extender.
REQ-013 out_valid  output  1  execute-stage word valid.
REQ-014 out_ready  input  1  execute stage accepts word.
REQ-015 out_opcode/out_rd  output  6/5  registered copies.
REQ-016 out_a  output  DATA_W  ALU operand A (registered rs_data).
REQ-017 out_b  output  DATA_W  ALU operand B (immediate or rt_data, see REQ-022).
REQ-018 out_imm  output  DATA_W  final immediate after REQ-021/Configuration rules.
REQ-019 bubble_count  output  CNT_W  cycles with out_ready=1 and out_valid=0, saturating.

Function
REQ-020 Transfer on an interface occurs iff valid and ready are both 1 at a rising edge; accepted word appears on out_* exactly 1 cycle later if the output buffer was empty (latency 1, throughput 1 word/cycle).
REQ-021 ANDI(0x0C)/ORI(0x0D)/XORI(0x0E) SHALL force out_imm[31:16]=0 (zero-extend); all other opcodes pass in_imm_ext unchanged.
REQ-022 out_b SHALL equal out_imm for ADDI(0x08), ADDIU(0x09), SLTI(0x0A), ANDI, ORI, XORI, LW(0x23), SW(0x2B); otherwise rt_data.
REQ-023 Buffering is a main register plus one skid register; states EMPTY, ONE (main full), TWO (main+skid full).
REQ-024 Transitions: EMPTY-accept->ONE; ONE-accept&!drain->TWO; ONE-drain&!accept->EMPTY; ONE-accept&drain->ONE (new word into main); TWO-drain->ONE (skid moves to main); all other combinations hold state.
REQ-025 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-026 While out_valid=1 and out_ready=0, all out_* SHALL remain stable.
REQ-027 flush=1 SHALL move state to EMPTY next cycle, discard any word accepted in the same cycle, and has priority over every other event.
REQ-028 bubble_count increments when out_ready=1 and out_valid=0, saturates at 2^CNT_W-1, is not cleared by flush.

Reset
REQ-029 reset SHALL force state EMPTY, out_valid=0, in_ready=1, bubble_count=0, all out_* data buses=0.
REQ-030 reset asserted mid-transfer SHALL discard both held words; no word is emitted after reset deassertion until a new accept.

Configuration
REQ-031 Macro ID_EX_LUI_EN defined: LUI(0x0F) yields out_imm={in_imm_ext[15:0],16'h0000} and out_b=out_imm.
REQ-032 ID_EX_LUI_EN undefined: LUI is treated as a non-immediate opcode (out_imm=in_imm_ext, out_b=rt_data).

Structure
REQ-033 Opcode constants and the state encoding SHALL live in the shared cpu package.
REQ-034 The two-entry buffer SHALL be a sub-module pipe_skid_buffer parameterised by payload width; id_ex_stage holds the immediate/operand muxing and counter.

Verification
REQ-035 in_imm_ext=0xFFFFFFFF, opcode ADDI, out_ready=1 -> next cycle out_valid=1, out_b=0xFFFFFFFF; opcode ORI -> out_imm=0x0000FFFF.
REQ-036 out_ready=0, two consecutive accepts -> in_ready=0 after 2nd; out_ready=1 -> words emitted in order over 2 cycles, in_ready=1 again.
REQ-037 State TWO plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale word ever emitted.
REQ-038 in_imm_ext=0x00008000, opcode LUI -> out_imm=0x80000000 with ID_EX_LUI_EN, 0x00008000 without.
REQ-039 reset asserted between clock edges in state ONE -> out_valid=0 immediately, bubble_count=0.
REQ-040 CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_count=15 and holds.
